// File: rtl/sample_mm_pkg.sv
// ---------------------------------------------------------------------------
// sample_mm_pkg
//
// Shared definitions for the streaming-sample to Avalon-MM writer:
//   state_e         - FSM state encoding (IDLE, RUN, WR)
//   AVM_BYTEENABLE  - every write is a full 32-bit word, so all lanes on
// ---------------------------------------------------------------------------
package sample_mm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_WR   = 2'd2
   } state_e;

   localparam logic [3:0] AVM_BYTEENABLE = 4'hF;

endpackage

// File: rtl/sample_mm_writer.sv
// ---------------------------------------------------------------------------
// sample_mm_writer
//
// Takes 32-bit samples from a valid/ready stream and writes them as
// consecutive words to an Avalon-MM slave, starting at a latched base
// address. Runs either a single pass of num_words words or wraps around the
// buffer until stopped.
//
// Ports:
//   clk, reset_n           - clock, asynchronous active-low reset
//   start, stop            - one-cycle control pulses
//   base_addr, num_words,
//   circular               - transfer setup, latched on an accepted start
//   sink_data/valid/ready  - sample stream input
//   avm_address/write/
//   writedata/byteenable,
//   avm_waitrequest        - Avalon-MM write master
//   busy                   - transfer in progress (RUN or WR)
//   done                   - one-cycle pulse when a transfer ends
//   wr_count               - word index of the next write
// ---------------------------------------------------------------------------
module sample_mm_writer
   import sample_mm_pkg::*;
#(
   parameter int ADDR_W = 17,
   parameter int LEN_W  = 15
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              stop,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  num_words,
   input  logic              circular,
   input  logic [31:0]       sink_data,
   input  logic              sink_valid,
   output logic              sink_ready,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_write,
   output logic [31:0]       avm_writedata,
   output logic [3:0]        avm_byteenable,
   input  logic              avm_waitrequest,
   output logic              busy,
   output logic              done,
   output logic [LEN_W-1:0]  wr_count
);

   // Reset assertion is immediate; release is delayed two clocks so every
   // flop leaves reset on the same clean edge.
   logic [1:0] rst_sync_q;
   logic       rst_n_int;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign rst_n_int = rst_sync_q[1];

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  wr_count_q, wr_count_d;
   logic              circ_q, circ_d;
   logic              stop_pend_q, stop_pend_d;
   logic              done_q, done_d;
   logic [31:0]       data_q, data_d;

   logic              stop_any;
   logic              wr_done;
   logic              last_word;
   logic              more_words;
   logic              ready_int;
   logic              accept;
   logic [ADDR_W-1:0] word_offset;

   // A stop arriving this cycle counts the same as one already pending, so a
   // stop that coincides with a handshake blocks that sample.
   assign stop_any   = stop | stop_pend_q;
   assign wr_done    = (state_q == ST_WR) && !avm_waitrequest;
   assign last_word  = (wr_count_q == (len_q - LEN_W'(1)));
   assign more_words = circ_q || !last_word;

   // Ready is combinational in the completing WR cycle so that, with no wait
   // states, a new sample follows straight into WR at one word per clock.
   always_comb begin
      ready_int = 1'b0;
      case (state_q)
         ST_RUN:  ready_int = !stop_any;
         ST_WR:   ready_int = wr_done && more_words && !stop_any;
         default: ready_int = 1'b0;
      endcase
   end

   assign accept = sink_valid && ready_int;

   // Next-state logic for the transfer FSM and its datapath registers.
   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      len_d       = len_q;
      circ_d      = circ_q;
      wr_count_d  = wr_count_q;
      data_d      = data_q;
      done_d      = 1'b0;
      stop_pend_d = stop_pend_q | (stop && (state_q != ST_IDLE));

      case (state_q)
         ST_IDLE: begin
            stop_pend_d = 1'b0;
            if (start) begin
               if (num_words == '0) begin
                  // Nothing to move: report completion without going busy.
                  done_d = 1'b1;
               end else begin
                  base_d     = base_addr & ~ADDR_W'(3);
                  len_d      = num_words;
                  circ_d     = circular;
                  wr_count_d = '0;
                  state_d    = ST_RUN;
               end
            end
         end

         ST_RUN: begin
            if (stop_any) begin
               state_d     = ST_IDLE;
               done_d      = 1'b1;
               stop_pend_d = 1'b0;
            end else if (accept) begin
               data_d  = sink_data;
               state_d = ST_WR;
            end
         end

         ST_WR: begin
            if (wr_done) begin
               if (circ_q && last_word) begin
                  wr_count_d = '0;
               end else begin
                  wr_count_d = wr_count_q + LEN_W'(1);
               end

               // A stop seen during the stall takes effect only now, after
               // the outstanding write has been accepted by the slave.
               if (!more_words || stop_any) begin
                  state_d     = ST_IDLE;
                  done_d      = 1'b1;
                  stop_pend_d = 1'b0;
               end else if (accept) begin
                  data_d  = sink_data;
                  state_d = ST_WR;
               end else begin
                  state_d = ST_RUN;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n_int) begin
      if (!rst_n_int) begin
         state_q     <= ST_IDLE;
         base_q      <= '0;
         len_q       <= '0;
         circ_q      <= 1'b0;
         wr_count_q  <= '0;
         data_q      <= '0;
         done_q      <= 1'b0;
         stop_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         len_q       <= len_d;
         circ_q      <= circ_d;
         wr_count_q  <= wr_count_d;
         data_q      <= data_d;
         done_q      <= done_d;
         stop_pend_q <= stop_pend_d;
      end
   end

   // Word index to byte offset; the add wraps modulo 2^ADDR_W by truncation.
   assign word_offset    = ADDR_W'({wr_count_q, 2'b00});
   assign avm_address    = base_q + word_offset;
   assign avm_write      = (state_q == ST_WR);
   assign avm_writedata  = data_q;
   assign avm_byteenable = AVM_BYTEENABLE;
   assign sink_ready     = ready_int;
   assign busy           = (state_q != ST_IDLE);
   assign done           = done_q;
   assign wr_count       = wr_count_q;

endmodule

// File: tb/tb_sample_mm_writer.sv
// ---------------------------------------------------------------------------
// tb_sample_mm_writer
//
// Directed bench for sample_mm_writer. Inputs change 1 time unit after the
// rising edge; outputs are observed at the falling edge, where accepted
// samples, completed writes and done pulses are logged for later checks.
// ---------------------------------------------------------------------------
module tb_sample_mm_writer;

   localparam int ADDR_W = 17;
   localparam int LEN_W  = 15;
   localparam logic [31:0] DATA_BASE = 32'hA500_0000;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              start;
   logic              stop;
   logic [ADDR_W-1:0] base_addr;
   logic [LEN_W-1:0]  num_words;
   logic              circular;
   logic [31:0]       sink_data;
   logic              sink_valid;
   logic              sink_ready;
   logic [ADDR_W-1:0] avm_address;
   logic              avm_write;
   logic [31:0]       avm_writedata;
   logic [3:0]        avm_byteenable;
   logic              avm_waitrequest;
   logic              busy;
   logic              done;
   logic [LEN_W-1:0]  wr_count;

   int checks   = 0;
   int failures = 0;

   int          acc_cnt;
   int          done_cnt;
   int          wr_n;
   int          cyc;
   logic [31:0] wr_addr [16];
   logic [31:0] wr_data [16];
   int          wr_cyc  [16];

   sample_mm_writer #(
      .ADDR_W (ADDR_W),
      .LEN_W  (LEN_W)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .start           (start),
      .stop            (stop),
      .base_addr       (base_addr),
      .num_words       (num_words),
      .circular        (circular),
      .sink_data       (sink_data),
      .sink_valid      (sink_valid),
      .sink_ready      (sink_ready),
      .avm_address     (avm_address),
      .avm_write       (avm_write),
      .avm_writedata   (avm_writedata),
      .avm_byteenable  (avm_byteenable),
      .avm_waitrequest (avm_waitrequest),
      .busy            (busy),
      .done            (done),
      .wr_count        (wr_count)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Compares one observed value against its expected value.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
         $error("[TB] check %s did not hold", tag);
      end
   endtask

   // Sets the per-cycle control inputs.
   task automatic applyStimulus(input logic st, input logic sp, input logic vld, input logic wq);
      start           = st;
      stop            = sp;
      sink_valid      = vld;
      avm_waitrequest = wq;
   endtask

   // Observes one cycle at the falling edge, then advances past the next
   // rising edge; a new sample value is presented after each handshake.
   task automatic stepCycle();
      logic hs;
      @(negedge clk);
      hs = sink_valid && sink_ready;
      if (hs) acc_cnt++;
      if (avm_write && !avm_waitrequest) begin
         if (wr_n < 16) begin
            wr_addr[wr_n] = 32'(avm_address);
            wr_data[wr_n] = avm_writedata;
            wr_cyc[wr_n]  = cyc;
         end
         wr_n++;
      end
      if (done) done_cnt++;
      @(posedge clk);
      #1;
      cyc++;
      if (hs) sink_data = DATA_BASE + 32'(acc_cnt);
   endtask

   // Moves to just before the falling edge so combinational outputs can be read.
   task automatic peek();
      #3;
   endtask

   task automatic resetMonitors();
      acc_cnt   = 0;
      done_cnt  = 0;
      wr_n      = 0;
      cyc       = 0;
      sink_data = DATA_BASE;
   endtask

   // Steps until a done pulse has been seen, giving up after maxc cycles.
   task automatic waitDone(input string tag, input int maxc);
      int n;
      n = 0;
      while (done_cnt == 0 && n < maxc) begin
         stepCycle();
         n++;
      end
      checkOutput({tag, "_done_seen"}, 32'(done_cnt > 0), 32'd1);
   endtask

   initial begin
      reset_n   = 1'b0;
      base_addr = '0;
      num_words = '0;
      circular  = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      resetMonitors();

      // ---------------- reset state ----------------
      #2;
      checkOutput("rst_byteenable", 32'(avm_byteenable), 32'hF);
      checkOutput("rst_write",      32'(avm_write),      32'd0);
      checkOutput("rst_busy",       32'(busy),           32'd0);
      checkOutput("rst_done",       32'(done),           32'd0);
      checkOutput("rst_address",    32'(avm_address),    32'd0);
      checkOutput("rst_wdata",      avm_writedata,       32'd0);
      checkOutput("rst_wr_count",   32'(wr_count),       32'd0);
      checkOutput("rst_ready",      32'(sink_ready),     32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (3) stepCycle();
      checkOutput("idle_busy", 32'(busy), 32'd0);

      // ---------------- single pass, zero wait ----------------
      $display("[TB] single pass base 0x100 x4");
      resetMonitors();
      base_addr = 17'h100;
      num_words = 15'd4;
      circular  = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      waitDone("sp", 20);
      checkOutput("sp_busy_fell", 32'(busy), 32'd0);
      checkOutput("sp_nwrites",   32'(wr_n), 32'd4);
      checkOutput("sp_addr0", wr_addr[0], 32'h100);
      checkOutput("sp_addr1", wr_addr[1], 32'h104);
      checkOutput("sp_addr2", wr_addr[2], 32'h108);
      checkOutput("sp_addr3", wr_addr[3], 32'h10C);
      checkOutput("sp_data0", wr_data[0], DATA_BASE + 32'd0);
      checkOutput("sp_data3", wr_data[3], DATA_BASE + 32'd3);
      checkOutput("sp_back_to_back", 32'(wr_cyc[3] - wr_cyc[0]), 32'd3);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      repeat (3) stepCycle();
      checkOutput("sp_done_once", 32'(done_cnt), 32'd1);
      checkOutput("sp_accepted",  32'(acc_cnt),  32'd4);

      // ---------------- waitrequest stall on second write ----------------
      $display("[TB] stall on second write");
      resetMonitors();
      base_addr = 17'h100;
      num_words = 15'd4;
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      stepCycle();
      stepCycle();
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         peek();
         checkOutput($sformatf("stall%0d_write", i), 32'(avm_write),   32'd1);
         checkOutput($sformatf("stall%0d_addr", i),  32'(avm_address), 32'h104);
         checkOutput($sformatf("stall%0d_data", i),  avm_writedata,    DATA_BASE + 32'd1);
         checkOutput($sformatf("stall%0d_ready", i), 32'(sink_ready),  32'd0);
         stepCycle();
      end
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      waitDone("stall", 20);
      checkOutput("stall_nwrites", 32'(wr_n), 32'd4);
      checkOutput("stall_addr1",   wr_addr[1], 32'h104);
      checkOutput("stall_data1",   wr_data[1], DATA_BASE + 32'd1);
      checkOutput("stall_addr3",   wr_addr[3], 32'h10C);
      checkOutput("stall_data3",   wr_data[3], DATA_BASE + 32'd3);
      checkOutput("stall_accepted", 32'(acc_cnt), 32'd4);

      // ---------------- circular, stop during 7th write ----------------
      $display("[TB] circular x3 with stop");
      resetMonitors();
      base_addr = 17'h0;
      num_words = 15'd3;
      circular  = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      repeat (7) stepCycle();
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      peek();
      checkOutput("circ_w7_ready", 32'(sink_ready), 32'd0);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      stepCycle();
      checkOutput("circ_done_next", 32'(done_cnt), 32'd1);
      repeat (3) stepCycle();
      checkOutput("circ_nwrites", 32'(wr_n), 32'd7);
      checkOutput("circ_addr0", wr_addr[0], 32'h0);
      checkOutput("circ_addr2", wr_addr[2], 32'h8);
      checkOutput("circ_addr3", wr_addr[3], 32'h0);
      checkOutput("circ_addr5", wr_addr[5], 32'h8);
      checkOutput("circ_addr6", wr_addr[6], 32'h0);
      checkOutput("circ_data6", wr_data[6], DATA_BASE + 32'd6);
      checkOutput("circ_accepted", 32'(acc_cnt), 32'd7);
      checkOutput("circ_done_once", 32'(done_cnt), 32'd1);
      circular = 1'b0;

      // ---------------- zero-length start ----------------
      $display("[TB] zero length");
      resetMonitors();
      base_addr = 17'h100;
      num_words = 15'd0;
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      peek();
      checkOutput("zero_done",  32'(done),       32'd1);
      checkOutput("zero_busy",  32'(busy),       32'd0);
      checkOutput("zero_ready", 32'(sink_ready), 32'd0);
      repeat (4) stepCycle();
      checkOutput("zero_done_once", 32'(done_cnt), 32'd1);
      checkOutput("zero_nwrites",   32'(wr_n),     32'd0);

      // ---------------- start while busy, stop with valid in RUN ----------------
      $display("[TB] start ignored while busy, stop beats sample");
      resetMonitors();
      base_addr = 17'h200;
      num_words = 15'd8;
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      stepCycle();
      base_addr = 17'h40;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      stepCycle();
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      peek();
      checkOutput("busy_start_busy",     32'(busy),       32'd1);
      checkOutput("busy_start_count",    32'(wr_count),   32'd1);
      checkOutput("busy_start_addr",     32'(avm_address), 32'h204);
      checkOutput("stop_valid_ready",    32'(sink_ready), 32'd0);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      peek();
      checkOutput("stop_run_busy", 32'(busy), 32'd0);
      stepCycle();
      checkOutput("stop_run_done",     32'(done_cnt), 32'd1);
      checkOutput("stop_run_nwrites",  32'(wr_n),     32'd1);
      checkOutput("stop_run_addr0",    wr_addr[0],    32'h200);
      checkOutput("stop_run_accepted", 32'(acc_cnt),  32'd1);

      // ---------------- reset during WR ----------------
      $display("[TB] reset mid-write");
      resetMonitors();
      base_addr = 17'h300;
      num_words = 15'd4;
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      stepCycle();
      peek();
      checkOutput("mid_wr_write", 32'(avm_write), 32'd1);
      reset_n = 1'b0;
      #1;
      checkOutput("mid_rst_write",      32'(avm_write),      32'd0);
      checkOutput("mid_rst_address",    32'(avm_address),    32'd0);
      checkOutput("mid_rst_wdata",      avm_writedata,       32'd0);
      checkOutput("mid_rst_byteenable", 32'(avm_byteenable), 32'hF);
      checkOutput("mid_rst_busy",       32'(busy),           32'd0);
      checkOutput("mid_rst_ready",      32'(sink_ready),     32'd0);
      checkOutput("mid_rst_count",      32'(wr_count),       32'd0);
      checkOutput("mid_rst_done",       32'(done),           32'd0);
      repeat (2) stepCycle();
      reset_n = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      repeat (3) stepCycle();
      checkOutput("mid_rst_no_done", 32'(done_cnt), 32'd0);
      resetMonitors();
      base_addr = 17'h10;
      num_words = 15'd2;
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      waitDone("post_rst", 20);
      checkOutput("post_rst_nwrites", 32'(wr_n),     32'd2);
      checkOutput("post_rst_addr0",   wr_addr[0],    32'h10);
      checkOutput("post_rst_addr1",   wr_addr[1],    32'h14);
      checkOutput("post_rst_data1",   wr_data[1],    DATA_BASE + 32'd1);
      checkOutput("post_rst_done",    32'(done_cnt), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sample_mm_writer.md
SAMPLE_MM_WRITER -- requirements
Module: sample_mm_writer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 17, meaning the Avalon-MM master byte-address width.
REQ-002 The block SHALL have parameter LEN_W, default 15, meaning the transfer-length width in 32-bit words.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset; all state SHALL be clocked on the rising edge of clk.
REQ-004 Ports SHALL be as follows (name  direction  width  meaning):
 clk  in  1  system clock
 reset_n  in  1  asynchronous active-low reset
 start  in  1  one-cycle pulse that begins a transfer
 stop  in  1  one-cycle pulse that ends circular mode
 base_addr  in  ADDR_W  byte base address, word-aligned (bits [1:0] ignored)
 num_words  in  LEN_W  buffer length in words
 circular  in  1  1 = wrap and run until stop; 0 = single pass
 sink_data  in  32  streaming sample
 sink_valid  in  1  sample valid
 sink_ready  out  1  sample accepted when valid and ready are both high
 avm_address  out  ADDR_W  master byte address
 avm_write  out  1  write request
 avm_writedata  out  32  write data
 avm_byteenable  out  4  always 4'hF
 avm_waitrequest  in  1  slave stall
 busy  out  1  transfer in progress
 done  out  1  one-cycle completion pulse
 wr_count  out  LEN_W  word index of the next write

Function
REQ-005 The FSM SHALL have states IDLE, RUN and WR.
REQ-006 In IDLE, a start pulse SHALL latch base_addr, num_words and circular, clear wr_count to 0 and enter RUN on the next cycle.
REQ-007 A start pulse with num_words==0 SHALL stay in IDLE, generate no write and pulse done in the following cycle.
REQ-008 A start pulse while busy SHALL be ignored.
REQ-009 In RUN, sink_ready SHALL be 1; a sample accepted in RUN SHALL be registered into avm_writedata, and the FSM SHALL enter WR.
REQ-010 In WR, avm_write SHALL be 1 and avm_address SHALL equal latched base + 4*wr_count; address and data SHALL stay stable while avm_waitrequest is 1.
REQ-011 A write SHALL complete in the cycle where avm_write=1 and avm_waitrequest=0; in that cycle wr_count SHALL advance.
REQ-012 In the completing WR cycle, sink_ready SHALL be 1 if further words remain and no stop is pending, so a back-to-back sample goes directly into WR (one word per clock at zero wait states).
REQ-013 If no sample is accepted in the completing cycle and words remain, the FSM SHALL return to RUN.
REQ-014 wr_count SHALL wrap from num_words-1 to 0 in circular mode.
REQ-015 In single-pass mode, completion of word num_words-1 SHALL end the transfer: enter IDLE and pulse done in the next cycle.
REQ-016 A stop pulse SHALL set a stop-pending flag; no new sample SHALL be accepted after it.
REQ-017 A stop in RUN SHALL end the transfer immediately.
REQ-018 A stop in WR SHALL let the outstanding write complete before the transfer ends.
REQ-019 When a stop coincides with a sample handshake in RUN, the stop SHALL win, and the sample SHALL not be accepted.
REQ-020 busy SHALL be 1 in RUN and WR; sink_ready and avm_write SHALL be 0 in IDLE.
REQ-021 Address arithmetic SHALL be modulo 2^ADDR_W.

Reset
REQ-022 When reset_n=0, the FSM SHALL enter IDLE and all outputs SHALL be 0, except avm_byteenable, which SHALL be 4'hF.
REQ-023 Reset asserted mid-write SHALL abandon the write without producing a done pulse.
REQ-024 Reset release SHALL be synchronised to clk.

Structure
REQ-025 The state encoding and the byteenable constant SHALL live in a shared package, sample_mm_pkg.
REQ-026 The block SHALL be a single module with no sub-modules.

Verification
REQ-027 Single pass with base=0x100, num_words=4, continuous valid and waitrequest=0: writes SHALL go to 0x100, 0x104, 0x108 and 0x10C on consecutive cycles, then done SHALL pulse once and busy SHALL fall.
REQ-028 Hold waitrequest=1 for 3 cycles on the second write: address 0x104 and its data SHALL be held stable, no sample SHALL be accepted, and there SHALL be 4 writes total.
REQ-029 Circular mode with num_words=3 and 7 samples: addresses SHALL go 0,4,8,0,4,8,0; a stop during the 7th write SHALL give done after it completes, and no 8th write.
REQ-030 Start with num_words=0: there SHALL be no avm_write and done SHALL pulse 1 cycle later.
REQ-031 A start pulse during busy and a stop coincident with valid in RUN: the start SHALL be ignored, the sample SHALL not be accepted, and the transfer SHALL end.
REQ-032 Assert reset_n=0 during WR: all outputs SHALL be 0 (byteenable 4'hF) and a subsequent start SHALL work normally.
